// File: rtl/pwm_bank_pkg.sv
// Shared constants for pwm_bank: register map, CTRL bit positions and write decode kinds.
package pwm_bank_pkg;

  localparam int unsigned ADDR_CTRL     = 32'h00;
  localparam int unsigned ADDR_POLARITY = 32'hFD;
  localparam int unsigned ADDR_PRESCALE = 32'hFE;
  localparam int unsigned ADDR_ALL_OFF  = 32'hFF;

  localparam int unsigned CTRL_RUN    = 0;
  localparam int unsigned CTRL_AUX_OE = 1;

  typedef enum logic [2:0] {
    WR_NONE,
    WR_CTRL,
    WR_DUTY,
    WR_POLARITY,
    WR_PRESCALE,
    WR_ALL_OFF
  } wr_kind_e;

endpackage

// File: rtl/pwm_bank_channel.sv
// One PWM channel: double-buffered duty (pending/active), wrap-load, compare and output register.
module pwm_bank_channel #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             wrap,
  input  logic             all_off,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] counter,
  input  logic             pol,
  output logic             pwm
);

  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] pend_next;

  // A write landing on a wrap goes straight into active.
  assign pend_next = wr_en ? wr_data : pending;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending <= '0;
      active  <= '0;
      pwm     <= 1'b0;
    end else if (all_off) begin
      pending <= '0;
      active  <= '0;
      pwm     <= pol;
    end else begin
      pending <= pend_next;
      if (!run || wrap) begin
        active <= pend_next;
      end
      pwm <= run ? ((counter < active) ^ pol) : pol;
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: shared prescaler/counter, register decode, per-channel duty buffers.
// Optional POLARITY register at 0xFD enabled by defining PWM_BANK_POLARITY_EN.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int unsigned CHANNELS     = 7,
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned PRESCALE_RST = 511
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_valid,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick,
  output logic                aux_oe
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] PRE_RST = WIDTH'(PRESCALE_RST);

  logic             run;
  logic [WIDTH-1:0] prescale;
  logic [WIDTH-1:0] pre_cnt;
  logic [WIDTH-1:0] counter;
  logic             tick;
  logic             wrap;
  wr_kind_e         kind;

  always_comb begin
    kind = WR_NONE;
    if (wr_valid) begin
      if (wr_addr == ADDR_W'(ADDR_CTRL)) begin
        kind = WR_CTRL;
      end else if (wr_addr == ADDR_W'(ADDR_PRESCALE)) begin
        kind = WR_PRESCALE;
      end else if (wr_addr == ADDR_W'(ADDR_ALL_OFF)) begin
        kind = WR_ALL_OFF;
`ifdef PWM_BANK_POLARITY_EN
      end else if (wr_addr == ADDR_W'(ADDR_POLARITY)) begin
        kind = WR_POLARITY;
`endif
      end else if (wr_addr >= ADDR_W'(1) && wr_addr <= ADDR_W'(CHANNELS)) begin
        kind = WR_DUTY;
      end
    end
  end

  assign tick        = run && (pre_cnt == prescale);
  assign wrap        = tick && (counter == CNT_MAX);
  assign period_tick = wrap;

  always_ff @(posedge clk) begin
    if (!reset) begin
      run      <= 1'b1;
      aux_oe   <= 1'b0;
      prescale <= PRE_RST;
    end else begin
      if (kind == WR_CTRL) begin
        run    <= wr_data[CTRL_RUN];
        aux_oe <= wr_data[CTRL_AUX_OE];
      end
      if (kind == WR_PRESCALE) begin
        prescale <= wr_data;
      end
    end
  end

  // pre_cnt above a freshly lowered PRESCALE rolls over through 2^WIDTH-1 without ticking.
  always_ff @(posedge clk) begin
    if (!reset || !run) begin
      pre_cnt <= '0;
      counter <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
      counter <= counter + WIDTH'(1);
    end else begin
      pre_cnt <= pre_cnt + WIDTH'(1);
    end
  end

`ifdef PWM_BANK_POLARITY_EN
  logic [WIDTH-1:0] polarity;

  always_ff @(posedge clk) begin
    if (!reset) begin
      polarity <= '0;
    end else if (kind == WR_POLARITY) begin
      polarity <= wr_data;
    end
  end
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic pol_bit;
`ifdef PWM_BANK_POLARITY_EN
    assign pol_bit = polarity[i];
`else
    assign pol_bit = 1'b0;
`endif

    pwm_bank_channel #(.WIDTH(WIDTH)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .run     (run),
      .wrap    (wrap),
      .all_off (kind == WR_ALL_OFF),
      .wr_en   ((kind == WR_DUTY) && (wr_addr == ADDR_W'(i + 1))),
      .wr_data (wr_data),
      .counter (counter),
      .pol     (pol_bit),
      .pwm     (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: table of duty/prescale vectors measured per period,
// plus hand sequences for mid-period updates, wrap-cycle writes, ALL_OFF, run control and reset.
module tb_pwm_bank;

  localparam int unsigned CH = 7;
  localparam int unsigned W  = 8;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [CH-1:0] pwm_out;
  logic          period_tick;
  logic          aux_oe;

  always #5 clk = ~clk;

  pwm_bank #(.CHANNELS(CH), .WIDTH(W), .ADDR_W(AW), .PRESCALE_RST(511)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .aux_oe      (aux_oe)
  );

  typedef struct {
    int high;
    int ticks;
    int rises;
  } exp_t;

  typedef struct {
    int ch;
    int duty;
    int ps;
    int exp_high;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_tick(input string name);
    int n = 0;
    while (!period_tick && n < 2100) begin
      step();
      n++;
    end
    check({name, "_sync"}, int'(period_tick), 1);
  endtask

  // Window starts on a wrap cycle and spans exactly one period; optional write at cycle wr_at.
  task automatic measure(input string name, input int ch, input int len, input bit do_wr,
                         input int wr_at, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    int   high  = 0;
    int   ticks = 0;
    int   rises = 0;
    bit   prev;
    wait_tick(name);
    prev = pwm_out[ch];
    for (int i = 0; i < len; i++) begin
      if (do_wr && i == wr_at) begin
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
      end
      step();
      wr_valid = 1'b0;
      if (pwm_out[ch]) high++;
      if (pwm_out[ch] && !prev) rises++;
      prev = pwm_out[ch];
      if (period_tick) ticks++;
    end
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({name, "_high"}, high, e.high);
      check({name, "_ticks"}, ticks, e.ticks);
      check({name, "_rises"}, rises, e.rises);
      check({name, "_end_tick"}, int'(period_tick), 1);
    end
  endtask

  initial begin
    int hi;
    int tk;

    vecs[0] = '{0, 8'h40, 0, 64};
    vecs[1] = '{1, 8'h80, 0, 128};
    vecs[2] = '{6, 8'h01, 0, 1};
    vecs[3] = '{2, 8'hFF, 3, 1020};
    vecs[4] = '{4, 8'h00, 1, 0};
    vecs[5] = '{3, 8'hFE, 1, 508};

    reset    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    repeat (3) step();
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_tick", int'(period_tick), 0);
    check("rst_aux", int'(aux_oe), 0);
    reset = 1'b1;
    step();
    wr(8'hFE, 8'h00);

    for (int k = 0; k < 6; k++) begin
      wr(8'hFE, 8'(vecs[k].ps));
      wr(8'(vecs[k].ch + 1), 8'(vecs[k].duty));
      sb.push_back('{vecs[k].exp_high, 1, (vecs[k].duty > 0) ? 1 : 0});
      measure($sformatf("vec%0d", k), vecs[k].ch, 256 * (vecs[k].ps + 1), 1'b0, 0, 8'h0, 8'h0);
    end

    // Mid-period change keeps the old duty for the current period.
    wr(8'hFE, 8'h00);
    sb.push_back('{128, 1, 1});
    measure("mid_keep", 1, 256, 1'b1, 100, 8'h02, 8'h10);
    sb.push_back('{16, 1, 1});
    measure("mid_next", 1, 256, 1'b0, 0, 8'h0, 8'h0);

    // Write on the wrap cycle is active in the very next period.
    sb.push_back('{48, 1, 1});
    measure("wrap_wr", 0, 256, 1'b1, 0, 8'h01, 8'h30);

    // ALL_OFF mid-period clears outputs on the next cycle; prescale survives.
    wr(8'hFE, 8'h03);
    wait_tick("alloff");
    repeat (500) step();
    check("alloff_pre", int'(pwm_out[2]), 1);
    wr(8'hFF, 8'h00);
    check("alloff_now", int'(pwm_out), 0);
    sb.push_back('{0, 1, 0});
    measure("alloff_period", 2, 1024, 1'b0, 0, 8'h0, 8'h0);
    check("alloff_all", int'(pwm_out), 0);

    // run=0 holds everything low; resume gives a full first period.
    wr(8'h00, 8'h00);
    step();
    hi = 0;
    tk = 0;
    repeat (300) begin
      step();
      if (pwm_out != '0) hi++;
      if (period_tick) tk++;
    end
    check("run0_out", hi, 0);
    check("run0_tick", tk, 0);
    wr(8'h01, 8'h20);
    wr(8'hFE, 8'h00);
    repeat (5) step();
    check("run0_after_wr", int'(pwm_out), 0);
    wr(8'h00, 8'h01);
    check("resume_first", int'(pwm_out[0]), 0);
    hi = 0;
    for (int k = 1; k < 256; k++) begin
      step();
      if (k == 1) check("resume_second", int'(pwm_out[0]), 1);
      if (pwm_out[0]) hi++;
    end
    check("resume_high", hi, 32);
    check("resume_tick", int'(period_tick), 1);

    wr(8'h00, 8'h03);
    check("aux_on", int'(aux_oe), 1);
    wr(8'h00, 8'h01);
    check("aux_off", int'(aux_oe), 0);

    // POLARITY with duty 0: constant high when enabled, constant low otherwise.
    wr(8'hFD, 8'h01);
    wr(8'h01, 8'h00);
    wait_tick("pol");
    repeat (2) step();
    hi = 0;
    repeat (300) begin
      step();
      if (pwm_out[0]) hi++;
    end
`ifdef PWM_BANK_POLARITY_EN
    check("pol_high", hi, 300);
`else
    check("pol_high", hi, 0);
`endif
    wr(8'hFD, 8'h00);

    // Reset mid-period leaves no partial pulse.
    wr(8'h01, 8'h80);
    wait_tick("rst_mid");
    repeat (20) step();
    check("rst_mid_pre", int'(pwm_out[0]), 1);
    reset = 1'b0;
    step();
    check("rst_mid_pwm", int'(pwm_out), 0);
    check("rst_mid_tick", int'(period_tick), 0);
    reset = 1'b1;
    hi = 0;
    repeat (300) begin
      step();
      if (pwm_out != '0) hi++;
    end
    check("rst_mid_after", hi, 0);
    check("rst_mid_aux", int'(aux_oe), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
